prog_mealy_fsm: RTL and testbench

PROG_MEALY_FSM -- requirements
Module: prog_mealy_fsm

---
 rtl/prog_fsm_pkg.sv | 27 ++
 rtl/prog_mealy_fsm_if.sv | 32 +++
 rtl/prog_fsm_table.sv | 41 ++++
 rtl/prog_mealy_fsm.sv | 103 ++++++++++
 tb/tb_prog_mealy_fsm.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/prog_fsm_pkg.sv
// rtl/prog_fsm_pkg.sv - entry layout, entry type and width helper shared by prog_mealy_fsm
package prog_fsm_pkg;

    localparam int MAX_SW      = 6;
    localparam int MAX_OW      = 8;
    localparam int ENT_OUT_LSB = 0;

    // Widest entry any legal configuration can produce; narrower builds zero-extend.
    typedef struct packed {
        logic [MAX_SW-1:0] nxt;
        logic [MAX_OW-1:0] out;
    } entry_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int ent_next_lsb(input int ow);
        return ENT_OUT_LSB + ow;
    endfunction

endpackage

// File: rtl/prog_mealy_fsm_if.sv
// rtl/prog_mealy_fsm_if.sv - symbol stream and table-programming bus of prog_mealy_fsm
interface prog_mealy_fsm_if
    import prog_fsm_pkg::*;
#(
    parameter  int NSTATE = 4,
    parameter  int IW     = 1,
    parameter  int OW     = 1,
    localparam int SW     = clog2_min1(NSTATE)
) ();

    logic              clr;
    logic              in_valid;
    logic [IW-1:0]     x;
    logic [OW-1:0]     z;
    logic              z_valid;
    logic [NSTATE-1:0] state_oh;
    logic              cfg_we;
    logic [SW+IW-1:0]  cfg_addr;
    logic [SW+OW-1:0]  cfg_wdata;
    logic              cfg_err;

    modport master (
        output clr, in_valid, x, cfg_we, cfg_addr, cfg_wdata,
        input  z, z_valid, state_oh, cfg_err
    );

    modport slave (
        input  clr, in_valid, x, cfg_we, cfg_addr, cfg_wdata,
        output z, z_valid, state_oh, cfg_err
    );

endinterface

// File: rtl/prog_fsm_table.sv
// rtl/prog_fsm_table.sv - transition/output register file, one write port, async read port
module prog_fsm_table
    import prog_fsm_pkg::*;
#(
    parameter  int NSTATE     = 4,
    parameter  int IW         = 1,
    parameter  int OW         = 1,
    parameter  int INIT_STATE = 0,
    localparam int SW         = clog2_min1(NSTATE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [SW+IW-1:0] waddr_i,
    input  logic [SW+OW-1:0] wdata_i,
    input  logic [SW+IW-1:0] raddr_i,
    output logic [SW+OW-1:0] rdata_o
);

    localparam int               DEPTH       = NSTATE << IW;
    localparam logic [SW+OW-1:0] DEFAULT_ENT = {SW'(INIT_STATE), OW'(0)};

    logic [SW+OW-1:0] mem_q [DEPTH];
    logic             wr_in_range;

    // {state, x} equals state*2^IW + x, so the address indexes the array directly.
    assign wr_in_range = 32'(waddr_i[SW+IW-1:IW]) < NSTATE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DEFAULT_ENT;
            end
        end else if (we_i && wr_in_range) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_mealy_fsm.sv
// rtl/prog_mealy_fsm.sv - table-programmable Mealy FSM; PROG_FSM_ILLEGAL_TRAP_EN rejects illegal writes
module prog_mealy_fsm
    import prog_fsm_pkg::*;
#(
    parameter  int NSTATE     = 4,
    parameter  int IW         = 1,
    parameter  int OW         = 1,
    parameter  int INIT_STATE = 0,
    localparam int SW         = clog2_min1(NSTATE)
) (
    input  logic             clk,
    input  logic             reset,
    prog_mealy_fsm_if.slave  bus
);

    localparam int                NL       = ent_next_lsb(OW);
    localparam logic [SW-1:0]     INIT_IDX = SW'(INIT_STATE);
    localparam logic [NSTATE-1:0] OH_ONE   = NSTATE'(1);

    logic [SW-1:0]     state_q;
    logic [SW-1:0]     state_d;
    logic [NSTATE-1:0] state_oh_q;
    logic [SW+IW-1:0]  rd_addr;
    logic [SW+OW-1:0]  rd_data;
    entry_t            rd_ent;
    logic              step;
    logic              tbl_we;

    assign step    = bus.in_valid & ~bus.clr;
    assign rd_addr = {state_q, bus.x};

    prog_fsm_table #(
        .NSTATE     (NSTATE),
        .IW         (IW),
        .OW         (OW),
        .INIT_STATE (INIT_STATE)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we_i    (tbl_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        rd_ent     = '0;
        rd_ent.nxt = MAX_SW'(rd_data[SW+OW-1:NL]);
        rd_ent.out = MAX_OW'(rd_data[OW-1:ENT_OUT_LSB]);
    end

    // The read port sees the pre-write contents, so a same-cycle write never affects this lookup.
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = INIT_IDX;
        end else if (bus.in_valid) begin
            if (32'(rd_ent.nxt) < NSTATE) begin
                state_d = rd_ent.nxt[SW-1:0];
            end else begin
                state_d = INIT_IDX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT_IDX;
            state_oh_q <= OH_ONE << INIT_IDX;
        end else begin
            state_q    <= state_d;
            state_oh_q <= OH_ONE << state_d;
        end
    end

    assign bus.z        = step ? rd_ent.out[OW-1:0] : '0;
    assign bus.z_valid  = step;
    assign bus.state_oh = state_oh_q;

`ifdef PROG_FSM_ILLEGAL_TRAP_EN
    logic wr_legal;
    logic cfg_err_q;

    assign wr_legal = (32'(bus.cfg_addr[SW+IW-1:IW]) < NSTATE) &&
                      (32'(bus.cfg_wdata[SW+OW-1:OW]) < NSTATE);
    assign tbl_we   = bus.cfg_we & wr_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we & ~wr_legal;
        end
    end

    assign bus.cfg_err = cfg_err_q;
`else
    assign tbl_we      = bus.cfg_we;
    assign bus.cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// tb/tb_prog_mealy_fsm.sv - directed self-checking bench for prog_mealy_fsm
module tb_prog_mealy_fsm;

`ifdef PROG_FSM_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    prog_mealy_fsm_if #(.NSTATE(4),  .IW(1), .OW(1)) b4  ();
    prog_mealy_fsm_if #(.NSTATE(3),  .IW(1), .OW(1)) b3  ();
    prog_mealy_fsm_if #(.NSTATE(16), .IW(2), .OW(4)) b16 ();

    prog_mealy_fsm #(.NSTATE(4),  .IW(1), .OW(1), .INIT_STATE(0)) dut4  (.clk(clk), .reset(reset), .bus(b4));
    prog_mealy_fsm #(.NSTATE(3),  .IW(1), .OW(1), .INIT_STATE(0)) dut3  (.clk(clk), .reset(reset), .bus(b3));
    prog_mealy_fsm #(.NSTATE(16), .IW(2), .OW(4), .INIT_STATE(0)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr4(input logic [2:0] a, input logic [2:0] d);
        b4.cfg_we = 1'b1; b4.cfg_addr = a; b4.cfg_wdata = d;
        @(negedge clk);
        b4.cfg_we = 1'b0;
    endtask

    task automatic step4(input string tag, input logic x, input logic ez, input logic [3:0] eoh);
        b4.in_valid = 1'b1; b4.x = x;
        #1;
        check({tag, "_z"}, 32'(b4.z), 32'(ez));
        @(posedge clk); #1;
        check({tag, "_oh"}, 32'(b4.state_oh), 32'(eoh));
        @(negedge clk);
        b4.in_valid = 1'b0;
    endtask

    task automatic step3(input string tag, input logic x, input logic ez, input logic [2:0] eoh);
        b3.in_valid = 1'b1; b3.x = x;
        #1;
        check({tag, "_z"}, 32'(b3.z), 32'(ez));
        @(posedge clk); #1;
        check({tag, "_oh"}, 32'(b3.state_oh), 32'(eoh));
        @(negedge clk);
        b3.in_valid = 1'b0;
    endtask

    task automatic step16(input string tag, input logic [1:0] x, input logic [3:0] ez, input logic [15:0] eoh);
        b16.in_valid = 1'b1; b16.x = x;
        #1;
        check({tag, "_z"}, 32'(b16.z), 32'(ez));
        @(posedge clk); #1;
        check({tag, "_oh"}, 32'(b16.state_oh), 32'(eoh));
        @(negedge clk);
        b16.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        b4.clr = 0;  b4.in_valid = 0;  b4.x = 0;  b4.cfg_we = 0;  b4.cfg_addr = 0;  b4.cfg_wdata = 0;
        b3.clr = 0;  b3.in_valid = 0;  b3.x = 0;  b3.cfg_we = 0;  b3.cfg_addr = 0;  b3.cfg_wdata = 0;
        b16.clr = 0; b16.in_valid = 0; b16.x = 0; b16.cfg_we = 0; b16.cfg_addr = 0; b16.cfg_wdata = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_oh4", 32'(b4.state_oh), 32'h1);
        check("rst_err4", 32'(b4.cfg_err), 32'h0);
        check("rst_z4", 32'(b4.z), 32'h0);
        check("rst_oh16", 32'(b16.state_oh), 32'h1);

        // Classic table, wdata = {next[1:0], out}
        wr4(3'd0, 3'd4); wr4(3'd1, 3'd3); wr4(3'd2, 3'd6); wr4(3'd3, 3'd2);
        wr4(3'd4, 3'd0); wr4(3'd5, 3'd7); wr4(3'd6, 3'd2); wr4(3'd7, 3'd0);

        step4("seq0", 1'b1, 1'b1, 4'b0010);
        step4("seq1", 1'b0, 1'b0, 4'b1000);
        step4("seq2", 1'b1, 1'b0, 4'b0001);
        step4("seq3", 1'b1, 1'b1, 4'b0010);
        step4("seq4", 1'b0, 1'b0, 4'b1000);

        b4.x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_z", 32'(b4.z), 32'h0);
            check("hold_zv", 32'(b4.z_valid), 32'h0);
            @(posedge clk); #1;
            check("hold_oh", 32'(b4.state_oh), 32'b1000);
            @(negedge clk);
        end

        b4.clr = 1'b1; b4.in_valid = 1'b1; b4.x = 1'b1;
        #1;
        check("clr_zv", 32'(b4.z_valid), 32'h0);
        check("clr_z", 32'(b4.z), 32'h0);
        @(posedge clk); #1;
        check("clr_oh", 32'(b4.state_oh), 32'b0001);
        @(negedge clk);
        b4.clr = 1'b0; b4.in_valid = 1'b0;

        // Lookup and rewrite of {0,1} in the same cycle
        b4.in_valid = 1'b1; b4.x = 1'b1;
        b4.cfg_we = 1'b1; b4.cfg_addr = 3'd1; b4.cfg_wdata = 3'd4;
        #1;
        check("coll_z", 32'(b4.z), 32'h1);
        @(posedge clk); #1;
        check("coll_oh", 32'(b4.state_oh), 32'b0010);
        @(negedge clk);
        b4.in_valid = 1'b0; b4.cfg_we = 1'b0;

        step4("back0", 1'b0, 1'b0, 4'b1000);
        step4("back1", 1'b1, 1'b0, 4'b0001);
        step4("newent", 1'b1, 1'b0, 4'b0100);
        step4("to3", 1'b1, 1'b1, 4'b1000);

        // Reset between edges, with a write pending on {0,1}
        b4.cfg_we = 1'b1; b4.cfg_addr = 3'd1; b4.cfg_wdata = 3'd3;
        #2;
        reset = 1'b1;
        #1;
        check("arst_oh", 32'(b4.state_oh), 32'b0001);
        @(posedge clk);
        @(negedge clk);
        b4.cfg_we = 1'b0;
        reset = 1'b0;
        step4("arst_e01", 1'b1, 1'b0, 4'b0001);
        step4("arst_e00", 1'b0, 1'b0, 4'b0001);

        // Three-state table: out-of-range next index and out-of-range state address
        b3.cfg_we = 1'b1; b3.cfg_addr = 3'd1; b3.cfg_wdata = 3'd2;
        @(negedge clk);
        check("n3_err_ok", 32'(b3.cfg_err), 32'h0);
        b3.cfg_addr = 3'd2; b3.cfg_wdata = 3'd7;
        @(negedge clk);
        check("n3_err_nxt", 32'(b3.cfg_err), 32'(TRAP));
        b3.cfg_addr = 3'd6; b3.cfg_wdata = 3'd2;
        @(negedge clk);
        check("n3_err_st", 32'(b3.cfg_err), 32'(TRAP));
        b3.cfg_we = 1'b0;
        @(negedge clk);
        check("n3_err_end", 32'(b3.cfg_err), 32'h0);
        step3("n3_go1", 1'b1, 1'b0, 3'b010);
        step3("n3_oor", 1'b0, TRAP ? 1'b0 : 1'b1, 3'b001);

        // Sixteen-state ring advancing on x=01, out = s ^ 4'hA
        for (int s = 0; s < 16; s++) begin
            b16.cfg_we = 1'b1;
            b16.cfg_addr = 6'((s << 2) | 1);
            b16.cfg_wdata = 8'((((s + 1) % 16) << 4) | (s ^ 10));
            @(negedge clk);
        end
        b16.cfg_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step16("ring", 2'b01, 4'(k ^ 10), 16'(1 << ((k + 1) % 16)));
        end
        step16("ring_x2", 2'b10, 4'h0, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
